// File: rtl/readout_pkg.sv
// readout_pkg: shared types and constants for the readout frame path
package readout_pkg;
  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, TRAILER} state_t;
  localparam int HDR_BYTES = 4;
  localparam int TRL_BYTES = 4;
  localparam logic [15:0] DEF_HEADER_MAGIC = 16'hAA55;
  localparam logic [15:0] DEF_TRAILER_MAGIC = 16'h5AA5;
  localparam logic [1:0] RUN_STATE_RUNNING = 2'b10;
  // Byte i of a 4-byte field, counted MSB-first.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[{~i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/fifo_frame_reader_if.sv
// fifo_frame_reader_if: FIFO readout, TCP transmit and status signals of the frame reader
interface fifo_frame_reader_if #(parameter int DATA_W = 32);
  logic enable;
  logic [DATA_W:0] fifo_dout;
  logic fifo_empty;
  logic fifo_rd_en;
  logic tcp_tx_full;
  logic tcp_tx_wr;
  logic [7:0] tcp_tx_data;
  logic busy;
  logic [15:0] frame_cnt;
  modport master (
    input enable, fifo_dout, fifo_empty, tcp_tx_full,
    output fifo_rd_en, tcp_tx_wr, tcp_tx_data, busy, frame_cnt
  );
  modport slave (
    output enable, fifo_dout, fifo_empty, tcp_tx_full,
    input fifo_rd_en, tcp_tx_wr, tcp_tx_data, busy, frame_cnt
  );
endinterface

// File: rtl/word_to_byte_serializer.sv
// word_to_byte_serializer: splits a DATA_W word into bytes, MSB first, one per unstalled cycle
module word_to_byte_serializer #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              stall,
  input  logic [DATA_W-1:0] din,
  output logic [7:0]        byte_out,
  output logic              idle,
  output logic              last_byte
);
  localparam int BYTES = DATA_W / 8;
  localparam int CW = $clog2(BYTES + 1);
  logic [DATA_W-1:0] sreg;
  logic [CW-1:0] cnt;
  // The loading cycle already emits the MSB byte straight from din, so cnt holds the bytes still pending.
  assign idle = cnt == '0;
  assign byte_out = idle ? din[DATA_W-1 -: 8] : sreg[DATA_W-1 -: 8];
  assign last_byte = idle ? (BYTES == 1) : (cnt == CW'(1));
  always_ff @(posedge clk)
    if (!rst_n) begin
      sreg <= '0;
      cnt <= '0;
    end else if (!stall && (load || !idle)) begin
      sreg <= (idle ? din : sreg) << 8;
      cnt <= idle ? CW'(BYTES - 1) : cnt - 1'b1;
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: pops frame-tagged FWFT words and streams them as header/payload/trailer bytes
module fifo_frame_reader
  import readout_pkg::*;
#(
  parameter int          DATA_W        = 32,
  parameter logic [15:0] HEADER_MAGIC  = DEF_HEADER_MAGIC,
  parameter logic [15:0] TRAILER_MAGIC = DEF_TRAILER_MAGIC
) (
  input logic clk,
  input logic rst_n,
  fifo_frame_reader_if.master bus
);
  state_t state;
  logic [1:0] idx;
  logic [15:0] word_cnt, frame_cnt;
  logic flag, tx_wr, rd_en, emit, ser_idle, last_byte, word_end;
  logic [7:0] tx_data, ser_byte;
  assign rd_en = rst_n && state == PAYLOAD && ser_idle && !bus.fifo_empty && !bus.tcp_tx_full;
  assign emit = state == PAYLOAD && !bus.tcp_tx_full && (rd_en || !ser_idle);
  // The frame-end flag is live on the capture cycle and latched for the remaining bytes.
  assign word_end = last_byte && (rd_en ? bus.fifo_dout[DATA_W] : flag);
  word_to_byte_serializer #(.DATA_W(DATA_W)) ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (rd_en),
    .stall    (!emit),
    .din      (bus.fifo_dout[DATA_W-1:0]),
    .byte_out (ser_byte),
    .idle     (ser_idle),
    .last_byte(last_byte)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      word_cnt <= '0;
      frame_cnt <= '0;
      flag <= 1'b0;
      tx_wr <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_wr <= 1'b0;
      case (state)
        IDLE: state <= bus.enable && !bus.fifo_empty ? HEADER : IDLE;
        HEADER:
          if (!bus.tcp_tx_full) begin
            tx_wr <= 1'b1;
            tx_data <= byte_of({HEADER_MAGIC, frame_cnt}, idx);
            idx <= idx + 1'b1;
            state <= idx == 2'(HDR_BYTES - 1) ? PAYLOAD : HEADER;
          end
        PAYLOAD:
          if (emit) begin
            tx_wr <= 1'b1;
            tx_data <= ser_byte;
            word_cnt <= rd_en ? word_cnt + 1'b1 : word_cnt;
            flag <= rd_en ? bus.fifo_dout[DATA_W] : flag;
            state <= word_end ? TRAILER : PAYLOAD;
          end
        TRAILER:
          if (!bus.tcp_tx_full) begin
            tx_wr <= 1'b1;
            tx_data <= byte_of({TRAILER_MAGIC, word_cnt}, idx);
            idx <= idx + 1'b1;
            if (idx == 2'(TRL_BYTES - 1)) begin
              frame_cnt <= frame_cnt + 1'b1;
              word_cnt <= '0;
              state <= IDLE;
            end
          end
      endcase
    end
  assign bus.fifo_rd_en = rd_en;
  assign bus.tcp_tx_wr = tx_wr;
  assign bus.tcp_tx_data = tx_data;
  assign bus.busy = state != IDLE;
  assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: randomized frame traffic checked against a byte-stream reference model
module tb_fifo_frame_reader;
  import readout_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] run_state = 2'b00;
  always #5 clk = ~clk;
  fifo_frame_reader_if #(.DATA_W(32)) bus();
  assign bus.enable = run_state == RUN_STATE_RUNNING;
  fifo_frame_reader #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit hold = 1'b0;
  logic [32:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int got_cyc[$];
  int pop_cyc[$];
  logic [15:0] model_fc = '0;
  // FWFT FIFO model: pops on the strobe, new head visible shortly after the edge.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.fifo_rd_en === 1'b1) begin
      checks++;
      if (bus.fifo_empty !== 1'b0 || fifo_q.size() == 0) begin
        errors++;
        $display("FAIL pop_when_empty: rd_en=1 while fifo_empty=%b depth=%0d", bus.fifo_empty, fifo_q.size());
      end else begin
        fifo_q.delete(0);
        pop_cyc.push_back(cyc);
      end
    end
    #1;
    bus.fifo_empty = hold || fifo_q.size() == 0;
    bus.fifo_dout = fifo_q.size() != 0 ? fifo_q[0] : '0;
  end
  always @(negedge clk)
    if (bus.tcp_tx_wr === 1'b1) begin
      got_q.push_back(bus.tcp_tx_data);
      got_cyc.push_back(cyc);
    end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic void expect_frame(input logic [31:0] w[$]);
    logic [15:0] n = 16'(w.size());
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h55);
    exp_q.push_back(model_fc[15:8]);
    exp_q.push_back(model_fc[7:0]);
    foreach (w[i])
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[i][8*b +: 8]);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_q.push_back(n[15:8]);
    exp_q.push_back(n[7:0]);
    model_fc++;
  endfunction
  function automatic void push_words(input logic [31:0] w[$], input int from);
    for (int i = from; i < w.size(); i++) fifo_q.push_back({i == w.size() - 1, w[i]});
  endfunction
  function automatic void plan_frame(input logic [31:0] w[$]);
    push_words(w, 0);
    expect_frame(w);
  endfunction
  function automatic int first_diff();
    int n = got_q.size() < exp_q.size() ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return got_q.size() == exp_q.size() ? -1 : n;
  endfunction
  function automatic void clear_streams();
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
    pop_cyc.delete();
  endfunction
  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    repeat (budget) begin
      @(negedge clk);
      #1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.tcp_tx_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.tcp_tx_wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", bus.tcp_tx_wr); end
    checks++;
    if (bus.tcp_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.tcp_tx_data); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.frame_cnt !== 16'h0000) begin errors++; $display("FAIL reset_frame_cnt: got %h want 0000", bus.frame_cnt); end
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
    rst_n = 1'b1;
    model_fc = '0;
  endtask
  task automatic test_single_frame;
    logic [31:0] w[$];
    bit ok;
    int d;
    clear_streams();
    w.push_back(32'h11223344);
    w.push_back(32'h55667788);
    plan_frame(w);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(16, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got %0d bytes want 16", got_q.size()); end
    repeat (3) @(negedge clk);
    run_state = 2'b00;
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL single_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (pop_cyc.size() != 2) begin errors++; $display("FAIL single_pops: got %0d want 2", pop_cyc.size()); end
    else begin
      checks++;
      if (pop_cyc[1] - pop_cyc[0] != 4) begin errors++; $display("FAIL single_pop_gap: got %0d want 4", pop_cyc[1] - pop_cyc[0]); end
    end
    checks++;
    if (got_cyc.size() != 16 || got_cyc[15] - got_cyc[0] != 15) begin errors++; $display("FAIL single_contiguous: got span %0d want 15", got_cyc.size() ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1); end
    checks++;
    if (bus.frame_cnt !== 16'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d want 1", bus.frame_cnt); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", bus.busy); end
  endtask
  task automatic test_backpressure;
    logic [31:0] w[$];
    bit ok;
    int d;
    clear_streams();
    repeat (3) w.push_back($urandom);
    plan_frame(w);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(5, 100, ok);
    bus.tcp_tx_full = 1'b1;
    repeat (5) @(negedge clk);
    bus.tcp_tx_full = 1'b0;
    wait_bytes(20, 100, ok);
    run_state = 2'b00;
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got %0d bytes want 20", got_q.size()); end
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL bp_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (got_cyc.size() < 20 || got_cyc[5] - got_cyc[4] != 6) begin errors++; $display("FAIL bp_gap: got %0d want 6", got_cyc.size() >= 6 ? got_cyc[5] - got_cyc[4] : -1); end
    checks++;
    if (got_cyc.size() < 20 || got_cyc[19] - got_cyc[0] != 24) begin errors++; $display("FAIL bp_span: got %0d want 24", got_cyc.size() >= 20 ? got_cyc[19] - got_cyc[0] : -1); end
    checks++;
    if (bus.frame_cnt !== model_fc) begin errors++; $display("FAIL bp_frame_cnt: got %0d want %0d", bus.frame_cnt, model_fc); end
  endtask
  task automatic test_enable_drop;
    logic [31:0] w[$], w2[$];
    bit ok;
    int d;
    clear_streams();
    repeat (3) w.push_back($urandom);
    w2.push_back($urandom);
    plan_frame(w);
    push_words(w2, 0);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(4, 100, ok);
    run_state = 2'b01;
    wait_bytes(20, 100, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (got_q.size() != 20) begin errors++; $display("FAIL drop_bytes: got %0d want 20", got_q.size()); end
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL drop_stream: byte %0d got %h want %h", d, got_q[d], exp_q[d]); end
    checks++;
    if (pop_cyc.size() != 3) begin errors++; $display("FAIL drop_pops: got %0d want 3", pop_cyc.size()); end
    checks++;
    if (bus.busy !== 1'b0 || fifo_q.size() != 1) begin errors++; $display("FAIL drop_idle: busy %b depth %0d want 0 and 1", bus.busy, fifo_q.size()); end
    expect_frame(w2);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(32, 100, ok);
    run_state = 2'b00;
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL drop_resume: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
  endtask
  task automatic test_fifo_gap;
    logic [31:0] w[$];
    bit ok;
    int d;
    clear_streams();
    repeat (3) w.push_back($urandom);
    expect_frame(w);
    fifo_q.push_back({1'b0, w[0]});
    run_state = RUN_STATE_RUNNING;
    wait_bytes(8, 100, ok);
    run_state = 2'b00;
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 8 || bus.busy !== 1'b1) begin errors++; $display("FAIL gap_wait: got %0d bytes busy %b want 8 and 1", got_q.size(), bus.busy); end
    push_words(w, 1);
    wait_bytes(20, 100, ok);
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL gap_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (got_q.size() < 20 || {got_q[18], got_q[19]} !== 16'h0003) begin errors++; $display("FAIL gap_word_cnt: got %h%h want 0003", got_q[18], got_q[19]); end
  endtask
  task automatic test_frame_cnt_wrap;
    logic [31:0] w[$];
    bit ok;
    int d;
    clear_streams();
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.frame_cnt;
    model_fc = 16'hFFFF;
    w.push_back($urandom);
    plan_frame(w);
    w.delete();
    w.push_back($urandom);
    plan_frame(w);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(12, 100, ok);
    checks++;
    if (bus.frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_to_zero: got %h want 0000", bus.frame_cnt); end
    wait_bytes(24, 100, ok);
    run_state = 2'b00;
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL wrap_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (got_cyc.size() < 24 || got_cyc[12] - got_cyc[11] != 2) begin errors++; $display("FAIL wrap_idle_gap: got %0d want 2", got_cyc.size() >= 13 ? got_cyc[12] - got_cyc[11] : -1); end
    checks++;
    if (bus.frame_cnt !== model_fc) begin errors++; $display("FAIL wrap_frame_cnt: got %h want %h", bus.frame_cnt, model_fc); end
  endtask
  task automatic test_reset_mid_frame;
    logic [31:0] w[$], rem[$];
    bit ok;
    int d;
    clear_streams();
    repeat (3) w.push_back($urandom);
    plan_frame(w);
    run_state = RUN_STATE_RUNNING;
    wait_bytes(6, 100, ok);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.tcp_tx_wr !== 1'b0 || bus.busy !== 1'b0 || bus.frame_cnt !== 16'h0000 || bus.fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: wr %b busy %b frame_cnt %h rd_en %b want 0 0 0000 0", bus.tcp_tx_wr, bus.busy, bus.frame_cnt, bus.fifo_rd_en);
    end
    rst_n = 1'b1;
    clear_streams();
    model_fc = '0;
    rem.push_back(w[1]);
    rem.push_back(w[2]);
    expect_frame(rem);
    wait_bytes(16, 100, ok);
    run_state = 2'b00;
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL midreset_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (fifo_q.size() != 0) begin errors++; $display("FAIL midreset_fifo: depth %0d want 0", fifo_q.size()); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] w[$];
    bit ok, prev_full;
    int d, total, min_gap;
    clear_streams();
    for (int f = 0; f < 6; f++) begin
      w.delete();
      repeat ($urandom_range(1, 4)) w.push_back($urandom);
      plan_frame(w);
    end
    total = exp_q.size();
    run_state = RUN_STATE_RUNNING;
    wait_bytes(total, 2000, ok);
    run_state = 2'b00;
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL b2b_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (!ok || got_cyc[got_cyc.size()-1] - got_cyc[0] != total - 1 + 5) begin errors++; $display("FAIL b2b_span: got %0d want %0d", got_cyc.size() ? got_cyc[got_cyc.size()-1] - got_cyc[0] : -1, total + 4); end
    min_gap = 1000;
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] - pop_cyc[i-1] < min_gap) min_gap = pop_cyc[i] - pop_cyc[i-1];
    checks++;
    if (min_gap < 4) begin errors++; $display("FAIL b2b_pop_rate: min gap %0d want >= 4", min_gap); end
    checks++;
    if (bus.frame_cnt !== model_fc) begin errors++; $display("FAIL b2b_frame_cnt: got %0d want %0d", bus.frame_cnt, model_fc); end
    clear_streams();
    for (int f = 0; f < 5; f++) begin
      w.delete();
      repeat ($urandom_range(1, 4)) w.push_back($urandom);
      plan_frame(w);
    end
    total = exp_q.size();
    run_state = RUN_STATE_RUNNING;
    prev_full = 1'b0;
    for (int k = 0; k < 3000 && got_q.size() < total; k++) begin
      @(negedge clk);
      checks++;
      if (prev_full && bus.tcp_tx_wr !== 1'b0) begin errors++; $display("FAIL stall_wr: got %b want 0 after full", bus.tcp_tx_wr); end
      prev_full = $urandom_range(0, 3) == 0;
      bus.tcp_tx_full = prev_full;
    end
    bus.tcp_tx_full = 1'b0;
    run_state = 2'b00;
    repeat (3) @(negedge clk);
    d = first_diff();
    checks++;
    if (d >= 0) begin errors++; $display("FAIL stall_stream: byte %0d got %h want %h (%0d vs %0d bytes)", d, got_q[d], exp_q[d], got_q.size(), exp_q.size()); end
    checks++;
    if (bus.frame_cnt !== model_fc) begin errors++; $display("FAIL stall_frame_cnt: got %0d want %0d", bus.frame_cnt, model_fc); end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_enable_drop();
    test_fifo_gap();
    test_frame_cnt_wrap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
